wb_mem_responder: RTL and testbench

- Parametrised multi-channel Wishbone memory slave for the CPU bench.
- Replaces the fixed single-latency instruction and data responders behind CPU_TOP's instr_* and data_* buses.
- Serves NUM_CH Wishbone master channels from one shared word-addressed memory.
- Provides round-robin arbitration, programmable ack latency and an optional error response.

---
 rtl/wb_mem_pkg.sv | 18 +
 rtl/wb_rr_arbiter.sv | 41 ++++
 rtl/wb_mem_responder.sv | 148 ++++++++++++++
 tb/tb_wb_mem_responder.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/wb_mem_pkg.sv
// Shared types and helpers for the multi-channel Wishbone memory responder.
package wb_mem_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } wb_state_e;

  // Grant index width; never narrower than one bit, even for a single channel.
  function automatic int ch_idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr wins,
// scanning upward modulo NUM_CH. The pointer register lives in the parent.
module wb_rr_arbiter
  import wb_mem_pkg::*;
#(
  parameter int NUM_CH = 2,
  localparam int IDX_W = ch_idx_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  input  logic              enable,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx,
  output logic [IDX_W-1:0]  next_ptr
);

  always_comb begin
    logic found;
    int   j;
    grant     = '0;
    grant_idx = '0;
    next_ptr  = ptr;
    found     = 1'b0;
    j         = 0;
    if (enable) begin
      for (int i = 0; i < NUM_CH; i++) begin
        j = int'(ptr) + i;
        if (j >= NUM_CH) begin
          j = j - NUM_CH;
        end
        if (!found && req[j]) begin
          found     = 1'b1;
          grant[j]  = 1'b1;
          grant_idx = IDX_W'(j);
          next_ptr  = (j + 1 >= NUM_CH) ? '0 : IDX_W'(j + 1);
        end
      end
    end
  end

endmodule

// File: rtl/wb_mem_responder.sv
// Multi-channel Wishbone memory slave: round-robin arbitration, programmable
// ack latency. Define WB_MEM_RESPONDER_ERR_EN to add ch_err_o for out-of-range addresses.
module wb_mem_responder
  import wb_mem_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int ADDR_W     = DEFAULT_ADDR_W,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 1
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic [NUM_CH-1:0]        ch_stb_i,
  input  logic [NUM_CH-1:0]        ch_we_i,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr_i,
  input  logic [NUM_CH*DATA_W-1:0] ch_data_i,
  output logic [NUM_CH*DATA_W-1:0] ch_data_o,
  output logic [NUM_CH-1:0]        ch_ack_o
`ifdef WB_MEM_RESPONDER_ERR_EN
  ,
  output logic [NUM_CH-1:0]        ch_err_o
`endif
);

  localparam int IDX_W = ch_idx_w(NUM_CH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  wb_state_e             state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [IDX_W-1:0]      ptr_reg, ptr_next;
  logic [IDX_W-1:0]      gnt_reg;
  logic [DEPTH_LOG2-1:0] idx_reg;
  logic                  we_reg;
  logic                  err_reg;
  logic [DATA_W-1:0]     wdata_reg;
  logic [DATA_W-1:0]     rd_data_reg;

  logic [DATA_W-1:0]     mem [DEPTH];

  logic [NUM_CH-1:0]     arb_grant;
  logic [IDX_W-1:0]      arb_idx;
  logic [IDX_W-1:0]      arb_next_ptr;
  logic                  take;
  logic [ADDR_W-1:0]     sel_addr;
  logic [DATA_W-1:0]     sel_wdata;
  logic [DEPTH_LOG2-1:0] sel_idx;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic                  addr_err;
  logic                  unused_addr;
  logic                  ack_live;
  logic [NUM_CH-1:0]     hit;

  wb_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req       (ch_stb_i),
    .ptr       (ptr_reg),
    .enable    (state_reg == IDLE),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .next_ptr  (arb_next_ptr)
  );

  assign take      = |arb_grant;
  assign sel_addr  = ch_addr_i[arb_idx*ADDR_W +: ADDR_W];
  assign sel_wdata = ch_data_i[arb_idx*DATA_W +: DATA_W];
  assign sel_idx   = sel_addr[DEPTH_LOG2+1:2];

`ifdef WB_MEM_RESPONDER_ERR_EN
  assign addr_err    = |(sel_addr >> (DEPTH_LOG2 + 2));
  assign unused_addr = ^sel_addr[1:0];
`else
  assign addr_err    = 1'b0;
  assign unused_addr = ^{sel_addr[ADDR_W-1:DEPTH_LOG2+2], sel_addr[1:0]};
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      IDLE: begin
        if (take) begin
          ptr_next   = arb_next_ptr;
          cnt_next   = CNT_W'(LATENCY - 1);
          state_next = (LATENCY > 1) ? WAIT : ACK;
        end
      end
      WAIT: begin
        cnt_next = cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1)) begin
          state_next = ACK;
        end
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      ptr_reg   <= '0;
      gnt_reg   <= '0;
      idx_reg   <= '0;
      we_reg    <= 1'b0;
      err_reg   <= 1'b0;
      wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ptr_reg   <= ptr_next;
      if (take) begin
        gnt_reg   <= arb_idx;
        idx_reg   <= sel_idx;
        we_reg    <= ch_we_i[arb_idx];
        err_reg   <= addr_err;
        wdata_reg <= sel_wdata;
      end
    end
  end

  // Read one cycle ahead so the registered RAM output is valid in ACK.
  // A write commits at the end of ACK, so the next transaction's read sees it.
  assign rd_idx = (state_reg == IDLE) ? sel_idx : idx_reg;

  always_ff @(posedge sys_clk) begin
    if (state_reg == ACK && we_reg && !err_reg && !sys_rst) begin
      mem[idx_reg] <= wdata_reg;
    end
    rd_data_reg <= mem[rd_idx];
  end

  // Reset during ACK aborts the transaction, so it also suppresses the response.
  assign ack_live = (state_reg == ACK) && !sys_rst;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign hit[gi]      = ack_live && (gnt_reg == IDX_W'(gi));
    assign ch_ack_o[gi] = hit[gi] && !err_reg;
    assign ch_data_o[gi*DATA_W +: DATA_W] =
      (hit[gi] && !we_reg && !err_reg) ? rd_data_reg : '0;
`ifdef WB_MEM_RESPONDER_ERR_EN
    assign ch_err_o[gi] = hit[gi] && err_reg;
`endif
  end

endmodule

// File: tb/tb_wb_mem_responder.sv
// Scoreboard bench: three responders (LATENCY 1, 4, 3) share one clock and reset;
// drivers queue expected responses, a negedge monitor checks every ack/err.
module tb_wb_mem_responder;

`ifdef WB_MEM_RESPONDER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    int          dut;
    int          ch;
    bit          rd;
    logic [31:0] data;
    int          cyc;
    bit          err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          lat_tab [3] = '{1, 4, 3};
  exp_t        sb_q [$];

  logic [1:0]  stb   [3];
  logic [1:0]  we    [3];
  logic [63:0] addr  [3];
  logic [63:0] wdata [3];
  wire  [63:0] rdata [3];
  wire  [1:0]  ack   [3];
  wire  [1:0]  err   [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int LAT = (gi == 0) ? 1 : (gi == 1) ? 4 : 3;
    wb_mem_responder #(
      .NUM_CH(2), .DATA_W(32), .ADDR_W(32), .DEPTH_LOG2(10), .LATENCY(LAT)
    ) u_dut (
      .sys_clk   (clk),
      .sys_rst   (rst),
      .ch_stb_i  (stb[gi]),
      .ch_we_i   (we[gi]),
      .ch_addr_i (addr[gi]),
      .ch_data_i (wdata[gi]),
      .ch_data_o (rdata[gi]),
      .ch_ack_o  (ack[gi])
`ifdef WB_MEM_RESPONDER_ERR_EN
      ,
      .ch_err_o  (err[gi])
`endif
    );
`ifndef WB_MEM_RESPONDER_ERR_EN
    assign err[gi] = 2'b00;
`endif
  end

  task automatic check(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d: got 0x%08h expected 0x%08h at cycle %0d",
                  name, d, act, exp, cyc);
  endtask

  // Monitor: every response is matched against the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      if (ack[d] != 2'b00 || err[d] != 2'b00) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_ack dut%0d: got ack=%b err=%b expected none at cycle %0d",
                   d, ack[d], err[d], cyc);
        end else begin
          e = sb_q.pop_front();
          check("ack_dut",   d, 32'(d), 32'(e.dut));
          check("ack_vec",   d, 32'(ack[d]), e.err ? 32'd0 : 32'(1 << e.ch));
          check("err_vec",   d, 32'(err[d]), e.err ? 32'(1 << e.ch) : 32'd0);
          check("ack_cycle", d, 32'(cyc), 32'(e.cyc));
          check("rdata",     d, rdata[d][e.ch*32 +: 32], (e.rd && !e.err) ? e.data : 32'd0);
          check("idle_data", d, rdata[d][(1-e.ch)*32 +: 32], 32'd0);
        end
      end
    end
  end

  task automatic xact(input int d, input int ch, input bit wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] exp_rd, input bit exp_err);
    exp_t e;
    bit   got;
    @(posedge clk); #1;
    stb[d][ch]           = 1'b1;
    we[d][ch]            = wr;
    addr[d][ch*32 +: 32]  = a;
    wdata[d][ch*32 +: 32] = wd;
    e = '{d, ch, !wr, exp_rd, cyc + lat_tab[d], exp_err};
    sb_q.push_back(e);
    got = 1'b0;
    for (int t = 0; t < 32; t++) begin
      @(negedge clk);
      if (ack[d][ch] || err[d][ch]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_checks++;
      $display("FAIL timeout dut%0d ch%0d: got no response expected one within 32 cycles", d, ch);
    end
    @(posedge clk); #1;
    stb[d][ch] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    for (int d = 0; d < 3; d++) begin
      stb[d] = '0; we[d] = '0; addr[d] = '0; wdata[d] = '0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("rst_ack",  d, 32'(ack[d]), 32'd0);
      check("rst_data", d, rdata[d][31:0] | rdata[d][63:32], 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // Latency 1: preload, then write/read-back on ch1
    xact(0, 0, 1'b1, 32'h14, 32'hCAFEF00D, 32'h0, 1'b0);
    xact(0, 1, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    xact(0, 1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    // Latency 4: preload word 0, read it on ch0
    xact(1, 1, 1'b1, 32'h0, 32'h00000013, 32'h0, 1'b0);
    xact(1, 0, 1'b0, 32'h0, 32'h0, 32'h00000013, 1'b0);

    // Both channels requesting continuously: grants alternate ch0, ch1, ...
    @(posedge clk); #1;
    k = cyc;
    stb[0]  = 2'b11;
    we[0]   = 2'b00;
    addr[0] = {32'h14, 32'h10};
    for (int i = 0; i < 6; i++) begin
      sb_q.push_back('{0, i % 2, 1'b1, (i % 2 == 0) ? 32'hDEADBEEF : 32'hCAFEF00D,
                       k + 1 + 2 * i, 1'b0});
    end
    repeat (12) @(posedge clk);
    #1;
    stb[0] = 2'b00;

    // Latency 3: reset during WAIT of a write aborts it
    xact(2, 0, 1'b1, 32'h20, 32'h11, 32'h0, 1'b0);
    @(posedge clk); #1;
    stb[2][0] = 1'b1; we[2][0] = 1'b1; addr[2][31:0] = 32'h20; wdata[2][31:0] = 32'h55;
    @(posedge clk); #1;
    rst = 1'b1;
    stb[2][0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_ack", 2, 32'(ack[2]), 32'd0);
    xact(2, 0, 1'b0, 32'h20, 32'h0, 32'h11, 1'b0);

    // Address above the memory: alias to word 1, or error response when enabled
    xact(0, 1, 1'b1, 32'h4, 32'h11112222, 32'h0, 1'b0);
    xact(0, 1, 1'b1, 32'h1004, 32'h0BADF00D, 32'h0, ERR_EN);
    xact(0, 1, 1'b0, 32'h4, 32'h0, ERR_EN ? 32'h11112222 : 32'h0BADF00D, 1'b0);
    xact(0, 0, 1'b0, 32'h1004, 32'h0, ERR_EN ? 32'h0 : 32'h0BADF00D, ERR_EN);

    repeat (8) @(posedge clk);
    @(negedge clk);
    check("queue_drained", 0, 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
